// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode and the ID/EX register: ID fields, register-file
// read port, EX/MEM bypass, pipeline control and the registered EX-side outputs.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [RW-1:0] id_rd;
    logic [DW-1:0] id_imm;
    logic [DW-1:0] id_pc;
    logic [7:0]    id_ctrl;

    logic [RW-1:0] rf_addr1;
    logic [RW-1:0] rf_addr2;
    logic [DW-1:0] rf_data1;
    logic [DW-1:0] rf_data2;

    logic          exmem_regwrite;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;

    logic          flush;
    logic          ex_stall;
    logic          stall_req;

    logic          ex_valid;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_op1;
    logic [DW-1:0] ex_op2;
    logic [DW-1:0] ex_imm;
    logic [DW-1:0] ex_pc;
    logic [7:0]    ex_ctrl;
    logic [15:0]   perf_stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_imm, id_pc, id_ctrl,
        output rf_data1, rf_data2, exmem_regwrite, exmem_rd, exmem_result, flush, ex_stall,
        input  rf_addr1, rf_addr2, stall_req,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_op1, ex_op2, ex_imm, ex_pc, ex_ctrl,
        input  perf_stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_imm, id_pc, id_ctrl,
        input  rf_data1, rf_data2, exmem_regwrite, exmem_rd, exmem_result, flush, ex_stall,
        output rf_addr1, rf_addr2, stall_req,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_op1, ex_op2, ex_imm, ex_pc, ex_ctrl,
        output perf_stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand fetch with EX/MEM forwarding, load-use bubble insertion.
// Define IDEX_PERF_CNT_EN to build the saturating load-use stall counter.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    logic          exValid_q, exValid_d;
    logic [RW-1:0] exRs_q, exRs_d;
    logic [RW-1:0] exRt_q, exRt_d;
    logic [RW-1:0] exRd_q, exRd_d;
    logic [DW-1:0] exOp1_q, exOp1_d;
    logic [DW-1:0] exOp2_q, exOp2_d;
    logic [DW-1:0] exImm_q, exImm_d;
    logic [DW-1:0] exPc_q, exPc_d;
    logic [7:0]    exCtrl_q, exCtrl_d;

    logic          fwd1;
    logic          fwd2;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          loadUse;

    assign bus.rf_addr1 = bus.id_rs;
    assign bus.rf_addr2 = bus.id_rt;

    // Only EX/MEM needs bypassing here; MEM/WB arrives through register-file write-through.
    always_comb begin
        fwd1 = bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.id_rs);
        fwd2 = bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.id_rt);
        op1  = fwd1 ? bus.exmem_result : bus.rf_data1;
        op2  = fwd2 ? bus.exmem_result : bus.rf_data2;
    end

    // exCtrl_q[6] is memread: a load in EX whose target a valid ID instruction reads.
    always_comb begin
        loadUse = exValid_q && exCtrl_q[6] && (exRd_q != '0) && bus.id_valid &&
                  ((bus.id_use_rs && (exRd_q == bus.id_rs)) ||
                   (bus.id_use_rt && (exRd_q == bus.id_rt)));
    end

    assign bus.stall_req = loadUse || bus.ex_stall;

    always_comb begin
        exValid_d = exValid_q;
        exRs_d    = exRs_q;
        exRt_d    = exRt_q;
        exRd_d    = exRd_q;
        exOp1_d   = exOp1_q;
        exOp2_d   = exOp2_q;
        exImm_d   = exImm_q;
        exPc_d    = exPc_q;
        exCtrl_d  = exCtrl_q;
        if (bus.ex_stall) begin
            exValid_d = exValid_q;
        end else if (bus.flush || loadUse) begin
            // Bubble: data fields are don't-care, so they simply hold.
            exValid_d = 1'b0;
            exCtrl_d  = '0;
        end else begin
            exValid_d = bus.id_valid;
            exRs_d    = bus.id_rs;
            exRt_d    = bus.id_rt;
            exRd_d    = bus.id_rd;
            exOp1_d   = op1;
            exOp2_d   = op2;
            exImm_d   = bus.id_imm;
            exPc_d    = bus.id_pc;
            exCtrl_d  = bus.id_valid ? bus.id_ctrl : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exValid_q <= 1'b0;
            exRs_q    <= '0;
            exRt_q    <= '0;
            exRd_q    <= '0;
            exOp1_q   <= '0;
            exOp2_q   <= '0;
            exImm_q   <= '0;
            exPc_q    <= '0;
            exCtrl_q  <= '0;
        end else begin
            exValid_q <= exValid_d;
            exRs_q    <= exRs_d;
            exRt_q    <= exRt_d;
            exRd_q    <= exRd_d;
            exOp1_q   <= exOp1_d;
            exOp2_q   <= exOp2_d;
            exImm_q   <= exImm_d;
            exPc_q    <= exPc_d;
            exCtrl_q  <= exCtrl_d;
        end
    end

    assign bus.ex_valid = exValid_q;
    assign bus.ex_rs    = exRs_q;
    assign bus.ex_rt    = exRt_q;
    assign bus.ex_rd    = exRd_q;
    assign bus.ex_op1   = exOp1_q;
    assign bus.ex_op2   = exOp2_q;
    assign bus.ex_imm   = exImm_q;
    assign bus.ex_pc    = exPc_q;
    assign bus.ex_ctrl  = exCtrl_q;

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] stallCnt_q, stallCnt_d;

    // Counts only bubbles actually inserted by a load-use hazard; sticks at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (loadUse && !bus.ex_stall && !bus.flush && (stallCnt_q != 16'hFFFF))
            stallCnt_d = stallCnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stallCnt_q <= '0;
        else
            stallCnt_q <= stallCnt_d;
    end

    assign bus.perf_stall_cnt = stallCnt_q;
`else
    assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios, then
// randomized traffic against a behavioural model of the EX register contents.
module tb_id_ex_stage;

    logic clk;
    logic reset;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [7:0]  ctrl;
    } exModel_t;

    exModel_t    exp;
    exModel_t    frozen;
    int unsigned expCnt;
    logic [31:0] regs [32];
    logic        lastStallObs;
    int          totalChecks;
    int          badChecks;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] pickOperand(input logic [4:0] r, input logic [31:0] rfVal);
        if (bus.exmem_regwrite && bus.exmem_rd != 5'd0 && bus.exmem_rd == r)
            return bus.exmem_result;
        return rfVal;
    endfunction

    task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic [7:0] ctrl);
        bus.id_valid  = v;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_rd     = rd;
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_ctrl   = ctrl;
        bus.id_imm    = $urandom;
        bus.id_pc     = $urandom;
        bus.rf_data1  = regs[rs];
        bus.rf_data2  = regs[rt];
    endtask

    // One clock: check combinational outputs, advance the model, check the EX register.
    task automatic applyStimulus();
        logic     hazard;
        exModel_t nxt;
        #1;
        hazard = exp.valid && exp.ctrl[6] && (exp.rd != 5'd0) && bus.id_valid &&
                 ((bus.id_use_rs && exp.rd == bus.id_rs) || (bus.id_use_rt && exp.rd == bus.id_rt));
        lastStallObs = bus.stall_req;
        checkOutput("rf_addr1", 32'(bus.rf_addr1), 32'(bus.id_rs));
        checkOutput("rf_addr2", 32'(bus.rf_addr2), 32'(bus.id_rt));
        checkOutput("stall_req", 32'(bus.stall_req), 32'(hazard || bus.ex_stall));
        nxt = exp;
        if (!bus.ex_stall) begin
            if (bus.flush || hazard) begin
                nxt.valid = 1'b0;
                nxt.ctrl  = 8'h00;
            end else begin
                nxt.valid = bus.id_valid;
                nxt.rs    = bus.id_rs;
                nxt.rt    = bus.id_rt;
                nxt.rd    = bus.id_rd;
                nxt.op1   = pickOperand(bus.id_rs, bus.rf_data1);
                nxt.op2   = pickOperand(bus.id_rt, bus.rf_data2);
                nxt.imm   = bus.id_imm;
                nxt.pc    = bus.id_pc;
                nxt.ctrl  = bus.id_valid ? bus.id_ctrl : 8'h00;
            end
`ifdef IDEX_PERF_CNT_EN
            if (hazard && !bus.flush && expCnt < 32'd65535)
                expCnt++;
`endif
        end
        @(posedge clk);
        #1;
        exp = nxt;
        checkOutput("ex_valid", 32'(bus.ex_valid), 32'(exp.valid));
        checkOutput("ex_ctrl", 32'(bus.ex_ctrl), 32'(exp.ctrl));
        checkOutput("perf_stall_cnt", 32'(bus.perf_stall_cnt), expCnt);
        if (exp.valid) begin
            checkOutput("ex_rs", 32'(bus.ex_rs), 32'(exp.rs));
            checkOutput("ex_rt", 32'(bus.ex_rt), 32'(exp.rt));
            checkOutput("ex_rd", 32'(bus.ex_rd), 32'(exp.rd));
            checkOutput("ex_op1", bus.ex_op1, exp.op1);
            checkOutput("ex_op2", bus.ex_op2, exp.op2);
            checkOutput("ex_imm", bus.ex_imm, exp.imm);
            checkOutput("ex_pc", bus.ex_pc, exp.pc);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock arrives.
    task automatic doReset();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        checkOutput("rst_ex_op1", bus.ex_op1, 32'd0);
        checkOutput("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
        checkOutput("rst_perf", 32'(bus.perf_stall_cnt), 32'd0);
        checkOutput("rst_stall_req", 32'(bus.stall_req), 32'(bus.ex_stall));
        exp    = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, op1: 32'd0, op2: 32'd0,
                   imm: 32'd0, pc: 32'd0, ctrl: 8'h00};
        expCnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        reset       = 1'b1;
        regs[0]     = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        bus.exmem_regwrite = 1'b0;
        bus.exmem_rd       = 5'd0;
        bus.exmem_result   = 32'd0;
        bus.flush          = 1'b0;
        bus.ex_stall       = 1'b0;
        setId(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00);
        #1;
        doReset();

        // addu r3,r1,r2
        setId(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'h82);
        applyStimulus();
        checkOutput("addu_op1", bus.ex_op1, 32'd5);
        checkOutput("addu_op2", bus.ex_op2, 32'd7);
        checkOutput("addu_rd", 32'(bus.ex_rd), 32'd3);
        checkOutput("addu_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("addu_stall", 32'(lastStallObs), 32'd0);

        // EX/MEM forwarding, and r0 never forwarded
        bus.exmem_regwrite = 1'b1;
        bus.exmem_rd       = 5'd1;
        bus.exmem_result   = 32'hAA;
        setId(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'h82);
        applyStimulus();
        checkOutput("fwd_op1", bus.ex_op1, 32'hAA);
        bus.exmem_rd = 5'd0;
        setId(1'b1, 5'd0, 5'd2, 5'd3, 1'b1, 1'b1, 8'h82);
        applyStimulus();
        checkOutput("fwd_r0_op1", bus.ex_op1, 32'd0);
        bus.exmem_regwrite = 1'b0;

        // lw r4 then add r5,r4,r6: one bubble, then the add proceeds
        setId(1'b1, 5'd0, 5'd4, 5'd4, 1'b1, 1'b0, 8'hD8);
        applyStimulus();
        setId(1'b1, 5'd4, 5'd6, 5'd5, 1'b1, 1'b1, 8'h82);
        applyStimulus();
        checkOutput("lu_stall", 32'(lastStallObs), 32'd1);
        checkOutput("lu_bubble_ctrl", 32'(bus.ex_ctrl), 32'd0);
        checkOutput("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        applyStimulus();
        checkOutput("lu_after_stall", 32'(lastStallObs), 32'd0);
        checkOutput("lu_add_rd", 32'(bus.ex_rd), 32'd5);
        checkOutput("lu_add_valid", 32'(bus.ex_valid), 32'd1);
`ifdef IDEX_PERF_CNT_EN
        checkOutput("lu_perf", 32'(bus.perf_stall_cnt), 32'd1);
`endif

        // Load-use with flush: flush wins, counter untouched
        setId(1'b1, 5'd0, 5'd4, 5'd4, 1'b1, 1'b0, 8'hD8);
        applyStimulus();
        setId(1'b1, 5'd4, 5'd6, 5'd5, 1'b1, 1'b1, 8'h82);
        bus.flush = 1'b1;
        applyStimulus();
        bus.flush = 1'b0;
        checkOutput("flush_stall", 32'(lastStallObs), 32'd1);
        checkOutput("flush_bubble_valid", 32'(bus.ex_valid), 32'd0);
`ifdef IDEX_PERF_CNT_EN
        checkOutput("flush_perf", 32'(bus.perf_stall_cnt), 32'd1);
`endif

        // rt matches the load target but is not read: no stall
        setId(1'b1, 5'd0, 5'd4, 5'd4, 1'b1, 1'b0, 8'hD8);
        applyStimulus();
        setId(1'b1, 5'd6, 5'd4, 5'd7, 1'b1, 1'b0, 8'h82);
        applyStimulus();
        checkOutput("nouse_rt_stall", 32'(lastStallObs), 32'd0);
        checkOutput("nouse_rt_valid", 32'(bus.ex_valid), 32'd1);

        // EX stall for three cycles while ID keeps changing
        frozen = exp;
        bus.ex_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setId(1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'(10 + k), 1'b1, 1'b1, 8'h82);
            applyStimulus();
            checkOutput("exstall_req", 32'(lastStallObs), 32'd1);
            checkOutput("exstall_hold_rd", 32'(bus.ex_rd), 32'(frozen.rd));
            checkOutput("exstall_hold_op1", bus.ex_op1, frozen.op1);
        end
        bus.ex_stall = 1'b0;
        setId(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 8'h82);
        applyStimulus();
        checkOutput("exstall_release_rd", 32'(bus.ex_rd), 32'd9);
        checkOutput("exstall_release_op1", bus.ex_op1, 32'd5);

        // Reset in the middle of a load-use stall
        setId(1'b1, 5'd0, 5'd4, 5'd4, 1'b1, 1'b0, 8'hD8);
        applyStimulus();
        setId(1'b1, 5'd4, 5'd6, 5'd5, 1'b1, 1'b1, 8'h82);
        doReset();

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ctrl;
            ctrl = 8'($urandom);
            if ($urandom_range(0, 1) == 1) ctrl[6] = 1'b1;
            setId($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ctrl);
            bus.flush          = ($urandom_range(0, 9) == 0);
            bus.ex_stall       = ($urandom_range(0, 6) == 0);
            bus.exmem_regwrite = 1'($urandom_range(0, 1));
            bus.exmem_rd       = 5'($urandom_range(0, 3));
            bus.exmem_result   = $urandom;
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage of the pipelined MIPS core.
- Drives the register-file read addresses and captures both read operands.
- Forwards the EX/MEM result into those operands. MEM/WB bypass is already supplied by the register file's write-through.
- Detects load-use hazards, inserting bubbles and requesting a front-end stall.
- Registers all decoded control into the EX stage.

Parameters:
DW, 32, datapath width
RW, 5, register address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_rs  in  RW  source register 1
id_rt  in  RW  source register 2
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rd  in  RW  destination register, already muxed rd/rt/31
id_imm  in  DW  sign/zero-extended immediate
id_pc  in  DW  PC+4 of instruction
id_ctrl  in  8  {regwrite, memread, memwrite, memtoreg, alusrc, aluop[2:0]}
rf_addr1  out  RW  register-file read address 1
rf_addr2  out  RW  register-file read address 2
rf_data1  in  DW  register-file read data 1
rf_data2  in  DW  register-file read data 2
exmem_regwrite  in  1  EX/MEM instruction writes a register
exmem_rd  in  RW  EX/MEM destination
exmem_result  in  DW  EX/MEM ALU result
flush  in  1  branch/jump taken; kill the instruction in ID
ex_stall  in  1  EX busy; hold EX registers
stall_req  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX register holds a real instruction
ex_rs, ex_rt, ex_rd  out  RW  registered register addresses
ex_op1, ex_op2  out  DW  registered forwarded operands
ex_imm, ex_pc  out  DW  registered immediate and PC+4
ex_ctrl  out  8  registered control; all-zero for a bubble
perf_stall_cnt  out  16  load-use stall counter

Behaviour:
- rf_addr1 = id_rs and rf_addr2 = id_rt, combinationally.
- Operand select for op1: if exmem_regwrite && exmem_rd != 0 && exmem_rd == id_rs, use exmem_result; otherwise use rf_data1. op2 uses the same rule with id_rt and rf_data2.
- Register 0 is never forwarded and never causes a hazard.
- Load-use hazard (lu), combinational, asserted when all hold:
  - ex_valid && ex_ctrl.memread && ex_rd != 0;
  - id_valid;
  - (id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt).
- stall_req = lu || ex_stall.
- EX register update priority at the rising edge, highest first:
  1. ex_stall: all EX registers hold.
  2. flush: load a bubble (ex_valid = 0, ex_ctrl = 0; other fields don't-care, implemented as hold).
  3. lu: load a bubble. The ID instruction is re-presented next cycle because the front end is held.
  4. Otherwise: load the ID fields; ex_valid = id_valid; ex_ctrl = id_valid ? id_ctrl : 0.
- Stall behaviour:
  - A load-use stall lasts exactly one cycle. After the bubble, ex_valid = 0, so lu deasserts.
  - The load's result then reaches the operand via exmem forwarding.
- Simultaneous flush and lu: flush wins. stall_req still asserts that cycle; the front-end flush logic overrides it.
- Reset (asynchronous, any time, including mid-stall): ex_valid = 0, ex_ctrl = 0, all address/data outputs = 0, perf_stall_cnt = 0. stall_req follows combinationally from the reset state (0 unless ex_stall).
- Latency: one cycle from ID inputs to EX outputs.

Optional Feature:
Macro IDEX_PERF_CNT_EN.
- Defined: perf_stall_cnt increments by 1 on every rising edge where lu && !ex_stall && !flush. It saturates at 16'hFFFF and clears only on reset.
- Undefined: perf_stall_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset low mid-operation with ex_valid = 1 -> ex_valid = 0, ex_ctrl = 0, ex_op1 = 0 immediately, without waiting for a clock.
- ID addu r3,r1,r2 with rf_data1 = 5, rf_data2 = 7, no hazards -> next cycle ex_op1 = 5, ex_op2 = 7, ex_rd = 3, ex_valid = 1, stall_req = 0.
- exmem_regwrite = 1, exmem_rd = 1, exmem_result = 0xAA, id_rs = 1 -> ex_op1 = 0xAA. Repeat with exmem_rd = 0 and id_rs = 0 -> ex_op1 = rf_data1 (0).
- lw r4 in EX, then ID add r5,r4,r6 -> stall_req = 1 for one cycle, bubble (ex_ctrl = 0) in EX, add enters EX the following cycle. With IDEX_PERF_CNT_EN, perf_stall_cnt = 1.
- Same load-use setup with flush = 1 -> bubble, perf_stall_cnt unchanged. Setup with id_use_rt = 0 and ex_rd == id_rt -> no stall.
- ex_stall = 1 for 3 cycles while ID changes -> EX outputs frozen and stall_req = 1 throughout. After release, the current ID instruction loads.
